// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_pkg
// Description : Shared constants for the hazard/stall controller: the default
//               register-address width, the FSM state encodings and the
//               architectural zero-register index.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    // Default register-address width (32 architectural registers).
    localparam int REG_AW = 5;

    // Stall/flush FSM encodings. Encoding 2'd3 is unused and always
    // recovers to c_ST_RUN on the next clock.
    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_FLUSH    = 2'd2;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    localparam int c_ZERO_REG = 0;

endpackage
`default_nettype wire

// File: rtl/hazard_src_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_src_match
// Description : Compares one ID-stage source register against one producer
//               destination. Flags a match when the producer writes back,
//               the addresses are equal and the source is not register 0.
// Revision    : 1.0 - initial release
// Ports       : src   - source register read by the instruction in ID
//               dest  - destination register of the producing instruction
//               wb_en - producer actually writes dest
//               match - dependency present
// ============================================================================
module hazard_src_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] dest,
    input  logic              wb_en,
    output logic              match
);
    import hazard_stall_ctrl_pkg::*;

    localparam logic [REG_AW-1:0] c_ZERO_SRC = REG_AW'(c_ZERO_REG);

    assign match = wb_en && (src != c_ZERO_SRC) && (src == dest);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline hazard and stall controller. Detects RAW hazards
//               between the ID stage and the EXE/MEM producers, sequences
//               memory-wait freezes and branch flushes, and counts stall
//               cycles with a saturating counter.
// Revision    : 1.0 - initial release
// Config      : HAZARD_FORWARDING_EN - when defined, only load-use hazards
//               (EXE producer with exe_mem_r_en) stall; everything else is
//               assumed forwarded. When undefined, any EXE or MEM producer
//               match stalls.
// Ports       : clk, rst (async, active-low)
//               id_valid, id_src1, id_src2, id_uses_src2   - ID stage
//               exe_dest, exe_wb_en, exe_mem_r_en          - ID/EX register
//               mem_dest, mem_wb_en                        - EX/MEM register
//               br_taken, mem_req, mem_ready               - events
//               hazard_detected  - bubble into ID/EX
//               freeze_pc, freeze_ifid, flush_ifid, freeze_pipe
//               state_o          - current FSM state
//               stall_cnt        - saturating stall-cycle count
// ============================================================================
module hazard_stall_ctrl #(
    parameter int REG_AW = hazard_stall_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_uses_src2,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              hazard_detected,
    output logic              freeze_pc,
    output logic              freeze_ifid,
    output logic              flush_ifid,
    output logic              freeze_pipe,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt
);
    import hazard_stall_ctrl_pkg::*;

    // ------------------------------------------------------------------
    // Source/producer matching
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] w_src [2];
    logic [1:0]        w_src_used;
    logic [1:0]        w_exe_hit;
    logic              w_exe_en;
    logic              w_raw;

    assign w_src[0]   = id_src1;
    assign w_src[1]   = id_src2;
    // src2 only matters when it is a real register operand.
    assign w_src_used = {id_uses_src2, 1'b1};

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time.
    assign w_exe_en = exe_mem_r_en;

    // Producer fields not needed by the load-use policy.
    logic w_unused_ok;
    assign w_unused_ok = ^{exe_wb_en, mem_dest, mem_wb_en};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        hazard_src_match #(.REG_AW(REG_AW)) u_exe_match (
            .src   (w_src[gi]),
            .dest  (exe_dest),
            .wb_en (w_exe_en),
            .match (w_exe_hit[gi])
        );
    end

    assign w_raw = id_valid && ((w_exe_hit & w_src_used) != 2'b00);
`else
    logic [1:0] w_mem_hit;

    assign w_exe_en = exe_wb_en;

    // Load flag is irrelevant when every in-flight producer stalls.
    logic w_unused_ok;
    assign w_unused_ok = exe_mem_r_en;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        hazard_src_match #(.REG_AW(REG_AW)) u_exe_match (
            .src   (w_src[gi]),
            .dest  (exe_dest),
            .wb_en (w_exe_en),
            .match (w_exe_hit[gi])
        );
        hazard_src_match #(.REG_AW(REG_AW)) u_mem_match (
            .src   (w_src[gi]),
            .dest  (mem_dest),
            .wb_en (mem_wb_en),
            .match (w_mem_hit[gi])
        );
    end

    assign w_raw = id_valid && (((w_exe_hit | w_mem_hit) & w_src_used) != 2'b00);
`endif

    // ------------------------------------------------------------------
    // State and control decode (outputs are same-cycle combinational)
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_hz;
    logic             w_fpc;
    logic             w_fifd;
    logic             w_flush;
    logic             w_fpipe;
    logic             w_stall;

    always_comb begin
        w_hz         = 1'b0;
        w_fpc        = 1'b0;
        w_fifd       = 1'b0;
        w_flush      = 1'b0;
        w_fpipe      = 1'b0;
        w_next_state = c_ST_RUN;
        case (r_state)
            c_ST_RUN: begin
                // Priority: memory wait > branch flush > RAW stall.
                if (mem_req && !mem_ready) begin
                    w_fpipe      = 1'b1;
                    w_fpc        = 1'b1;
                    w_fifd       = 1'b1;
                    w_next_state = c_ST_MEM_WAIT;
                end else if (br_taken) begin
                    w_flush      = 1'b1;
                    w_hz         = 1'b1;
                    w_next_state = c_ST_FLUSH;
                end else if (w_raw) begin
                    w_hz         = 1'b1;
                    w_fpc        = 1'b1;
                    w_fifd       = 1'b1;
                end
            end
            c_ST_MEM_WAIT: begin
                // Outputs are fixed while waiting; only the memory
                // handshake decides when to leave.
                w_fpipe = 1'b1;
                w_fpc   = 1'b1;
                w_fifd  = 1'b1;
                if (mem_req && !mem_ready) begin
                    w_next_state = c_ST_MEM_WAIT;
                end
            end
            c_ST_FLUSH: begin
                // Bubble for the wrong-path instruction; branch ignored.
                w_hz = 1'b1;
            end
            default: begin
                w_next_state = c_ST_RUN;
            end
        endcase
    end

    // While reset is asserted every control output is forced low,
    // independent of the inputs.
    assign hazard_detected = rst && w_hz;
    assign freeze_pc       = rst && w_fpc;
    assign freeze_ifid     = rst && w_fifd;
    assign flush_ifid      = rst && w_flush;
    assign freeze_pipe     = rst && w_fpipe;

    assign w_stall = freeze_pc || freeze_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o   = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
